// File: rtl/led_pattern_gen_pkg.sv
// Shared types and helpers for the LED pattern generator: mode/dir encodings
// and the per-mode seed, evaluated bit by bit so it works for any WIDTH.
package led_pattern_pkg;

  typedef enum logic [2:0] {
    ROT_R  = 3'b000,
    CNT_UP = 3'b001,
    FILL   = 3'b010,
    BOUNCE = 3'b011,
    CNT_DN = 3'b100,
    HOLD   = 3'b101
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // HOLD and the two reserved codes are the only non-stepping modes
  function automatic logic mode_active(logic [2:0] m);
    return (m < 3'd5);
  endfunction

  function automatic logic seed_bit(logic [2:0] m, int unsigned width, int unsigned idx);
    case (m)
      ROT_R:   return (idx == width - 1);
      BOUNCE:  return (idx == 0);
      CNT_DN:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control/status bundle between the switch logic, the pattern generator and the LED pins.
interface led_pattern_gen_if #(parameter int WIDTH = 8);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] led;
  logic             wrap;

  modport master (output en, mode, input led, wrap);
  modport slave  (input en, mode, output led, wrap);
endinterface

// File: rtl/led_pattern_gen_tick_gen.sv
// Step prescaler: counts 0..DIV-1 on enabled cycles and flags the last count.
module tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_cnt <= '0;
    else if (clr)  r_cnt <= '0;
    else if (en)   r_cnt <= tick ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/led_pattern_gen.sv
// Multi-mode LED pattern generator: mode register, bounce direction, per-mode
// next-pattern logic and the registered end-of-period wrap pulse.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input logic              clk,
  input logic              reset_n,
  led_pattern_gen_if.slave bus
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2:0]       r_mode_q;
  logic [WIDTH-1:0] r_led, w_led_nxt, w_seed;
  dir_e             r_dir, w_dir_nxt;
  logic             r_wrap, w_wrap_nxt;
  logic             w_chg, w_tick, w_step;

  assign w_chg  = (bus.mode != r_mode_q);
  // a mode change wins over a prescaler tick on the same edge
  assign w_step = w_tick && !w_chg;

  tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (bus.en && mode_active(r_mode_q)),
    .clr     (w_chg),
    .tick    (w_tick)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_seed
    assign w_seed[i] = seed_bit(bus.mode, WIDTH, i);
  end

  always_comb begin
    w_led_nxt  = r_led;
    w_dir_nxt  = r_dir;
    w_wrap_nxt = 1'b0;
    case (r_mode_q)
      ROT_R: begin
        if (r_led[0]) begin w_led_nxt = MSB; w_wrap_nxt = 1'b1; end
        else            w_led_nxt = r_led >> 1;
      end
      CNT_UP: begin
        w_led_nxt  = r_led + 1'b1;
        w_wrap_nxt = &r_led;
      end
      FILL: begin
        if (r_led[0]) begin w_led_nxt = '0; w_wrap_nxt = 1'b1; end
        else            w_led_nxt = {1'b1, r_led[WIDTH-1:1]};
      end
      BOUNCE: begin
        if (r_dir == DIR_LEFT) begin
          if (r_led[WIDTH-1]) begin w_led_nxt = r_led >> 1; w_dir_nxt = DIR_RIGHT; end
          else                  w_led_nxt = r_led << 1;
        end else begin
          if (r_led[0]) begin
            w_led_nxt  = r_led << 1;
            w_dir_nxt  = DIR_LEFT;
            w_wrap_nxt = 1'b1;
          end else begin
            w_led_nxt = r_led >> 1;
          end
        end
      end
      CNT_DN: begin
        w_led_nxt  = r_led - 1'b1;
        w_wrap_nxt = ~|r_led;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led    <= ONE;
      r_mode_q <= ROT_R;
      r_dir    <= DIR_LEFT;
      r_wrap   <= 1'b0;
    end else if (w_chg) begin
      r_mode_q <= bus.mode;
      if (mode_active(bus.mode)) r_led <= w_seed;
      r_dir    <= DIR_LEFT;
      r_wrap   <= 1'b0;
    end else begin
      r_wrap <= w_step && w_wrap_nxt;
      if (w_step) begin
        r_led <= w_led_nxt;
        r_dir <= w_dir_nxt;
      end
    end
  end

  assign bus.led  = r_led;
  assign bus.wrap = r_wrap;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench: five generator configurations share one stimulus stream; a phase-index
// model predicts every instance each cycle, plus hand-computed checkpoints.
module tb_led_pattern_gen;
  localparam int N = 5;
  // instance configs, index 0..4: (8,1) (8,4) (8,3) (2,1) (16,1)
  localparam logic [N-1:0][7:0] WS = {8'd16, 8'd2, 8'd8, 8'd8, 8'd8};
  localparam logic [N-1:0][7:0] DS = {8'd1,  8'd1, 8'd3, 8'd4, 8'd1};

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [2:0] mode;
  logic [15:0] led_a  [N];
  logic        wrap_a [N];

  int checks = 0;
  int errors = 0;

  // model state: active mode, position within the period, prescaler count
  int          mq  [N];
  int          ph  [N];
  int          cnt [N];
  logic [15:0] held[N];
  bit          wr  [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    led_pattern_gen_if #(.WIDTH(int'(WS[g]))) bus();
    assign bus.en     = en;
    assign bus.mode   = mode;
    assign led_a[g]   = 16'(bus.led);
    assign wrap_a[g]  = bus.wrap;
    led_pattern_gen #(.WIDTH(int'(WS[g])), .DIV(int'(DS[g]))) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus));
  end

  function automatic logic [15:0] mled(int g);
    int w, mask, p;
    w = int'(WS[g]); mask = (1 << w) - 1; p = ph[g];
    case (mq[g])
      0:       return 16'(1 << (w - 1 - p));
      1:       return 16'(p);
      2:       return 16'((((1 << p) - 1) << (w - p)) & mask);
      3:       return 16'((p < w) ? (1 << p) : (1 << (2*w - 2 - p)));
      4:       return 16'(mask - p);
      default: return held[g];
    endcase
  endfunction

  function automatic int period(int g);
    int w;
    w = int'(WS[g]);
    case (mq[g])
      0:       return w;
      2:       return w + 1;
      default: return 1 << w;
    endcase
  endfunction

  task automatic model_reset();
    for (int g = 0; g < N; g++) begin
      mq[g] = 0; ph[g] = int'(WS[g]) - 1; cnt[g] = 0; wr[g] = 0; held[g] = '0;
    end
  endtask

  task automatic model_update();
    for (int g = 0; g < N; g++) begin
      if (!reset_n) begin
        mq[g] = 0; ph[g] = int'(WS[g]) - 1; cnt[g] = 0; wr[g] = 0;
      end else if (int'(mode) != mq[g]) begin
        if (mode < 3'd5) ph[g] = 0;
        else             held[g] = mled(g);
        mq[g] = int'(mode); cnt[g] = 0; wr[g] = 0;
      end else begin
        wr[g] = 0;
        if (en && mq[g] < 5) begin
          cnt[g]++;
          if (cnt[g] == int'(DS[g])) begin
            cnt[g] = 0;
            if (mq[g] == 3) begin
              if (ph[g] == 2*int'(WS[g]) - 2) begin ph[g] = 1; wr[g] = 1; end
              else ph[g]++;
            end else begin
              ph[g]++;
              if (ph[g] == period(g)) begin ph[g] = 0; wr[g] = 1; end
            end
          end
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic repc(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic lit(int g, logic [15:0] el, bit ew, string nm);
    checks++;
    if (led_a[g] !== el || wrap_a[g] !== ew) begin
      errors++;
      $display("FAIL %s inst%0d: dut led=%h wrap=%b, want led=%h wrap=%b",
               nm, g, led_a[g], wrap_a[g], el, ew);
    end
    checks++;
    if (mled(g) !== el || wr[g] !== ew) begin
      errors++;
      $display("FAIL %s_model inst%0d: model led=%h wrap=%b, want led=%h wrap=%b",
               nm, g, mled(g), wr[g], el, ew);
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      checks++;
      if (led_a[g] !== mled(g) || wrap_a[g] !== wr[g]) begin
        errors++;
        $display("FAIL cycle_cmp inst%0d t=%0t: dut led=%h wrap=%b, model led=%h wrap=%b",
                 g, $time, led_a[g], wrap_a[g], mled(g), wr[g]);
      end
    end
  end

  initial begin
    reset_n = 1'b0; en = 1'b0; mode = 3'b000;
    model_reset();
    cyc();
    lit(0, 16'h0001, 1'b0, "reset");
    lit(4, 16'h0001, 1'b0, "reset_w16");
    reset_n = 1'b1; en = 1'b1;

    // ROT_R from reset
    cyc();
    lit(0, 16'h0080, 1'b1, "rotr_first");
    lit(3, 16'h0002, 1'b1, "rotr_first_w2");
    lit(4, 16'h8000, 1'b1, "rotr_first_w16");
    cyc();    lit(0, 16'h0040, 1'b0, "rotr_step");
    repc(6);  lit(0, 16'h0001, 1'b0, "rotr_lsb");
    cyc();    lit(0, 16'h0080, 1'b1, "rotr_period");

    // CNT_UP full period, then switch to CNT_DN mid-count
    mode = 3'b001;
    cyc();    lit(0, 16'h0000, 1'b0, "cnt_reload");
    repc(255); lit(0, 16'h00FF, 1'b0, "cnt_ff");
    cyc();    lit(0, 16'h0000, 1'b1, "cnt_wrap");
    repc(5);  lit(0, 16'h0005, 1'b0, "cnt_mid");
    mode = 3'b100;
    cyc();    lit(0, 16'h00FF, 1'b0, "dn_reload");
    cyc();    lit(0, 16'h00FE, 1'b0, "dn_step");
    repc(254); lit(0, 16'h0000, 1'b0, "dn_zero");
    cyc();    lit(0, 16'h00FF, 1'b1, "dn_wrap");

    // FILL
    mode = 3'b010;
    cyc();    lit(0, 16'h0000, 1'b0, "fill_reload");
    cyc();    lit(0, 16'h0080, 1'b0, "fill_first");
    repc(7);  lit(0, 16'h00FF, 1'b0, "fill_full");
    cyc();    lit(0, 16'h0000, 1'b1, "fill_wrap");

    // BOUNCE, then async reset while moving right
    mode = 3'b011;
    cyc();    lit(0, 16'h0001, 1'b0, "bounce_reload");
    repc(7);  lit(0, 16'h0080, 1'b0, "bounce_top");
    repc(7);  lit(0, 16'h0001, 1'b0, "bounce_bottom");
    cyc();    lit(0, 16'h0002, 1'b1, "bounce_wrap");
    repc(7);  lit(0, 16'h0040, 1'b0, "bounce_right");
    #1 reset_n = 1'b0; model_reset();
    #1 lit(0, 16'h0001, 1'b0, "async_reset");
    cyc();
    reset_n = 1'b1;
    cyc();    lit(0, 16'h0001, 1'b0, "reset_release_reload");
    cyc();    lit(0, 16'h0002, 1'b0, "reload_dir_left");

    // DIV=4 with en gap
    mode = 3'b001;
    cyc();    lit(1, 16'h0000, 1'b0, "div4_reload");
    repc(4);  lit(1, 16'h0001, 1'b0, "div4_first");
    repc(2);
    en = 1'b0;
    repc(3);  lit(1, 16'h0001, 1'b0, "div4_en_hold");
              lit(0, 16'h0006, 1'b0, "en_low_hold");
    en = 1'b1;
    cyc();    lit(1, 16'h0001, 1'b0, "div4_no_skip");
    cyc();    lit(1, 16'h0002, 1'b0, "div4_resume");
              lit(2, 16'h0002, 1'b0, "div3_pre_chg");

    // mode change on the DIV=3 tick edge
    mode = 3'b000;
    cyc();    lit(2, 16'h0080, 1'b0, "chg_beats_tick");
    repc(2);  lit(2, 16'h0080, 1'b0, "div3_wait");
    cyc();    lit(2, 16'h0040, 1'b0, "div3_after_chg");
              lit(0, 16'h0010, 1'b0, "rotr_after_chg");

    // HOLD and reserved codes
    mode = 3'b101;
    cyc();    lit(0, 16'h0010, 1'b0, "hold_enter");
    repc(5);  lit(0, 16'h0010, 1'b0, "hold_frozen");
    mode = 3'b111;
    repc(4);  lit(0, 16'h0010, 1'b0, "rsv111_frozen");
    mode = 3'b110;
    repc(2);  lit(0, 16'h0010, 1'b0, "rsv110_frozen");
    mode = 3'b000;
    cyc();    lit(0, 16'h0080, 1'b0, "hold_exit");
    repc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
